// File: rtl/filtros_pkg.sv
// filtros_pkg: shared types, defaults and pointer wrap arithmetic for the filter datapath
package filtros_pkg;

    localparam int ANCHO_DATO_DEF = 8;
    localparam int ANCHO_DIR_DEF  = 16;

    typedef enum logic [1:0] {
        E_REPOSO,
        E_PEDIR,
        E_ESPERA,
        E_ENTREGA
    } estado_t;

    // Sum of two addresses; results beyond lim wrap back to base
    function automatic logic [31:0] wrap_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] base,
        input logic [31:0] lim
    );
        logic [31:0] s;
        s = a + b;
        return (s > lim) ? base + (s - lim - 32'd1) : s;
    endfunction

endpackage

// File: rtl/contador_direcciones_ventana.sv
// contador_direcciones_ventana: window address pointers (column base, current row address, column index)
//   clk, reset (sync, active-low)
//   actualizar_pos_mem : step one row down
//   liberar_bus_mem    : move to next column, restart at its top
//   reiniciar_dir      : back to pixel (0,0)
//   dir_actual         : address of the next pixel to read
//   fin_fila           : current column is the last of the row
module contador_direcciones_ventana
    import filtros_pkg::*;
#(
    parameter int ANCHO_DIR    = ANCHO_DIR_DEF,
    parameter int ANCHO_IMAGEN = 640,
    parameter int DIR_BASE     = 0,
    parameter int DIR_MAX      = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 actualizar_pos_mem,
    input  logic                 liberar_bus_mem,
    input  logic                 reiniciar_dir,
    output logic [ANCHO_DIR-1:0] dir_actual,
    output logic                 fin_fila
);

    localparam int ANCHO_COL = $clog2(ANCHO_IMAGEN);

    logic [ANCHO_DIR-1:0] col_base;
    logic [ANCHO_DIR-1:0] col_sig;
    logic [ANCHO_COL-1:0] columna;

    // Column base advances linearly, so stepping past the row end lands on the next row
    assign col_sig  = ANCHO_DIR'(wrap_add(32'(col_base), 32'd1, DIR_BASE, DIR_MAX));
    assign fin_fila = columna == ANCHO_COL'(ANCHO_IMAGEN - 1);

    always_ff @(posedge clk) begin
        if (!reset || reiniciar_dir) begin
            col_base   <= ANCHO_DIR'(DIR_BASE);
            dir_actual <= ANCHO_DIR'(DIR_BASE);
            columna    <= '0;
        end else if (liberar_bus_mem) begin
            col_base   <= col_sig;
            dir_actual <= col_sig;
            columna    <= fin_fila ? '0 : columna + ANCHO_COL'(1);
        end else if (actualizar_pos_mem) begin
            dir_actual <= ANCHO_DIR'(wrap_add(32'(dir_actual), ANCHO_IMAGEN, DIR_BASE, DIR_MAX));
        end
    end

endmodule

// File: rtl/responder_lectura_ventana.sv
// responder_lectura_ventana: serves single-pixel window-fill reads from a fixed-latency memory
//   clk, reset (sync, active-low)
//   leer_dato             : one-cycle read request
//   actualizar_pos_mem, liberar_bus_mem, reiniciar_dir : window pointer controls
//   mem_dato              : memory read data
//   dato_leido_disponible : one-cycle pulse, dato_leido valid
//   dato_leido            : last pixel read, held
//   mem_rd_en, mem_dir    : memory read strobe and registered address
//   bus_ocupado           : a read is in progress
//   fin_fila              : last column of the row
//   error_solicitud       : sticky, request arrived while busy
module responder_lectura_ventana
    import filtros_pkg::*;
#(
    parameter int ANCHO_DATO   = ANCHO_DATO_DEF,
    parameter int ANCHO_DIR    = ANCHO_DIR_DEF,
    parameter int ANCHO_IMAGEN = 640,
    parameter int LATENCIA_MEM = 2,
    parameter int DIR_BASE     = 0,
    parameter int DIR_MAX      = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  leer_dato,
    input  logic                  actualizar_pos_mem,
    input  logic                  liberar_bus_mem,
    input  logic                  reiniciar_dir,
    input  logic [ANCHO_DATO-1:0] mem_dato,
    output logic                  dato_leido_disponible,
    output logic [ANCHO_DATO-1:0] dato_leido,
    output logic                  mem_rd_en,
    output logic [ANCHO_DIR-1:0]  mem_dir,
    output logic                  bus_ocupado,
    output logic                  fin_fila,
    output logic                  error_solicitud
);

    localparam int ANCHO_CNT = $clog2(LATENCIA_MEM + 1);

    estado_t              estado, estado_sig;
    logic [ANCHO_CNT-1:0] cnt, cnt_sig;
    logic                 captura;
    logic [ANCHO_DIR-1:0] dir_actual;

    contador_direcciones_ventana #(
        .ANCHO_DIR   (ANCHO_DIR),
        .ANCHO_IMAGEN(ANCHO_IMAGEN),
        .DIR_BASE    (DIR_BASE),
        .DIR_MAX     (DIR_MAX)
    ) u_contador (
        .clk               (clk),
        .reset             (reset),
        .actualizar_pos_mem(actualizar_pos_mem),
        .liberar_bus_mem   (liberar_bus_mem),
        .reiniciar_dir     (reiniciar_dir),
        .dir_actual        (dir_actual),
        .fin_fila          (fin_fila)
    );

    assign mem_rd_en             = estado == E_PEDIR;
    assign dato_leido_disponible = estado == E_ENTREGA;
    assign bus_ocupado           = estado != E_REPOSO;

    // The counter holds the remaining wait cycles; the last one is the sampling cycle
    always_comb begin
        estado_sig = estado;
        cnt_sig    = cnt;
        captura    = 1'b0;
        case (estado)
            E_REPOSO:  estado_sig = leer_dato ? E_PEDIR : E_REPOSO;
            E_PEDIR: begin
                cnt_sig    = ANCHO_CNT'(LATENCIA_MEM);
                estado_sig = E_ESPERA;
            end
            E_ESPERA: begin
                cnt_sig    = cnt - ANCHO_CNT'(1);
                captura    = cnt == ANCHO_CNT'(1);
                estado_sig = captura ? E_ENTREGA : E_ESPERA;
            end
            E_ENTREGA: estado_sig = E_REPOSO;
            default:   estado_sig = E_REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado          <= E_REPOSO;
            cnt             <= '0;
            mem_dir         <= '0;
            dato_leido      <= '0;
            error_solicitud <= 1'b0;
        end else begin
            estado <= estado_sig;
            cnt    <= cnt_sig;
            // Address is frozen when the request is accepted, so same-cycle pointer moves cannot disturb it
            if (estado == E_REPOSO && leer_dato)
                mem_dir <= dir_actual;
            if (captura)
                dato_leido <= mem_dato;
            if (leer_dato && bus_ocupado)
                error_solicitud <= 1'b1;
        end
    end

endmodule
